// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded grant hold.
// Emits a registered grant index plus valid flag for a one-hot decoder.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n;
    logic [3:0] hcnt, hcnt_n;
    logic [2:0] idx_n;
    logic       valid_n;
    logic [2:0] g_next;
    logic [7:0] others;

    // First set bit of v scanning upward from p, wrapping past 7 to 0.
    function automatic logic [2:0] pick(input logic [7:0] v, input logic [2:0] p);
        logic [2:0] r;
        logic [2:0] k;
        logic       hit;
        r   = p;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            k = p + 3'(i);
            if (!hit && v[k]) begin
                r   = k;
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    assign g_next = gnt_idx + 3'd1;
    assign others = req & ~(8'b1 << gnt_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hcnt      <= 4'd0;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hcnt      <= hcnt_n;
            gnt_idx   <= idx_n;
            gnt_valid <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hcnt_n  = hcnt;
        idx_n   = gnt_idx;
        valid_n = gnt_valid;
        unique case (state)
            IDLE: begin
                if (req != 8'd0) begin
                    idx_n   = pick(req, ptr);
                    valid_n = 1'b1;
                    hcnt_n  = 4'd1;
                    state_n = GRANT;
                end else begin
                    valid_n = 1'b0;
                end
            end
            GRANT: begin
                if (!req[gnt_idx]) begin
                    ptr_n = g_next;
                    if (req != 8'd0) begin
                        idx_n  = pick(req, g_next);
                        hcnt_n = 4'd1;
                    end else begin
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end else if (hcnt >= HOLD_LIM && others != 8'd0) begin
                    // Hold limit reached with competition pending: rotate away.
                    ptr_n  = g_next;
                    idx_n  = pick(others, g_next);
                    hcnt_n = 4'd1;
                end else if (hcnt < HOLD_LIM) begin
                    hcnt_n = hcnt + 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed scoreboard bench for rr_arbiter_8 with MAX_HOLD = 4.
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int total;
    int bad;
    logic [3:0] exp_q[$];

    rr_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt_idx(gnt_idx),
        .gnt_valid(gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, queue the expected result, check after the edge.
    task automatic step(input string tag, input logic r, input logic [7:0] rq,
                        input logic ev, input logic [2:0] ei);
        logic [3:0] e;
        logic [3:0] o;
        @(negedge clk);
        rst = r;
        req = rq;
        exp_q.push_back({ev, ei});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        o = {gnt_valid, gnt_idx};
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s valid/idx got=%0b/%0d exp=%0b/%0d",
                   tag, o[3], o[2:0], e[3], e[2:0]);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 8'h00;

        step("reset0", 1'b1, 8'hFF, 1'b0, 3'd0);
        step("reset1", 1'b1, 8'hFF, 1'b0, 3'd0);
        for (int i = 0; i < 36; i++)
            step("full_load", 1'b0, 8'hFF, 1'b1, 3'((i / 4) % 8));

        step("rst_a", 1'b1, 8'h00, 1'b0, 3'd0);
        for (int i = 0; i < 10; i++)
            step("sole", 1'b0, 8'h10, 1'b1, 3'd4);

        step("rst_b", 1'b1, 8'h00, 1'b0, 3'd0);
        step("grant2", 1'b0, 8'h24, 1'b1, 3'd2);
        step("hold2", 1'b0, 8'h24, 1'b1, 3'd2);
        step("handoff5", 1'b0, 8'h20, 1'b1, 3'd5);

        step("drop", 1'b0, 8'h00, 1'b0, 3'd5);
        step("idle", 1'b0, 8'h00, 1'b0, 3'd5);
        step("wrap6", 1'b0, 8'h41, 1'b1, 3'd6);
        for (int i = 0; i < 3; i++)
            step("hold6", 1'b0, 8'h41, 1'b1, 3'd6);
        step("rot_wrap0", 1'b0, 8'h41, 1'b1, 3'd0);

        step("rst_c", 1'b1, 8'h00, 1'b0, 3'd0);
        step("grant3", 1'b0, 8'h08, 1'b1, 3'd3);
        step("hold3", 1'b0, 8'h08, 1'b1, 3'd3);
        step("rst_mid", 1'b1, 8'h08, 1'b0, 3'd0);
        step("regrant3", 1'b0, 8'h08, 1'b1, 3'd3);

        step("rel_new4", 1'b0, 8'h10, 1'b1, 3'd4);
        for (int i = 0; i < 3; i++)
            step("hold4", 1'b0, 8'h11, 1'b1, 3'd4);
        step("rot0", 1'b0, 8'h11, 1'b1, 3'd0);
        step("drop_all", 1'b0, 8'h00, 1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
